// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states, word width
// and the legal range of the response latency.
package dmem_pkg;

    localparam int WORD_W    = 32;
    localparam int LAT_CNT_W = 4;
    localparam int LAT_MIN   = 1;
    localparam int LAT_MAX   = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Out-of-range latencies are pulled into the range the 4-bit counter can express.
    function automatic int clamp_latency(input int lat);
        if (lat < LAT_MIN) return LAT_MIN;
        if (lat > LAT_MAX) return LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// MEM-stage data-memory request/response channels; the initiator is the master and
// the memory responder is the slave.
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous write, combinational read, contents not reset.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, response after LATENCY cycles.
// Optional MISALIGN_CHECK_EN flags non-word-aligned accesses and suppresses their stores.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);

    localparam int LAT = clamp_latency(LATENCY);
    localparam logic [LAT_CNT_W-1:0] CNT_INIT = LAT_CNT_W'((LAT >= 2) ? LAT - 2 : 0);

    state_t                  state_reg, state_next;
    logic [LAT_CNT_W-1:0]    cnt_reg, cnt_next;
    logic                    write_reg;
    logic                    mis_reg;
    logic [DEPTH_LOG2-1:0]   idx_reg;
    logic [WORD_W-1:0]       rdata_reg;
    logic                    err_reg;

    logic                    accept;
    logic                    load_resp;
    logic                    req_mis;
    logic                    cur_write;
    logic                    cur_mis;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [DEPTH_LOG2-1:0]   ram_addr;
    logic [WORD_W-1:0]       ram_rdata;
    logic                    ram_we;
    logic                    unused_addr_bits;

    assign req_idx = bus.req_addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{bus.req_addr[WORD_W-1:DEPTH_LOG2+2], bus.req_addr[1:0]};

`ifdef MISALIGN_CHECK_EN
    assign req_mis = (bus.req_addr[1:0] != 2'b00);
`else
    assign req_mis = 1'b0;
`endif

    assign accept = (state_reg == IDLE) && bus.req_valid;
    assign ram_we = accept && bus.req_write && !req_mis;

    // In IDLE the response may be captured on the accept edge itself (LATENCY == 1),
    // so the read port follows the live request; otherwise it follows the latched one.
    assign ram_addr  = (state_reg == IDLE) ? req_idx       : idx_reg;
    assign cur_write = (state_reg == IDLE) ? bus.req_write : write_reg;
    assign cur_mis   = (state_reg == IDLE) ? req_mis       : mis_reg;

    dmem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus.req_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load_resp  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (LAT == 1) begin
                        state_next = RESP;
                        load_resp  = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                    load_resp  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            write_reg <= 1'b0;
            mis_reg   <= 1'b0;
            idx_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                write_reg <= bus.req_write;
                mis_reg   <= req_mis;
                idx_reg   <= req_idx;
            end
            // Stores and flagged accesses return zero data.
            if (load_resp) begin
                rdata_reg <= (cur_write || cur_mis) ? '0 : ram_rdata;
                err_reg   <= cur_mis;
            end
        end
    end

    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.resp_valid = (state_reg == RESP);
    assign bus.resp_rdata = rdata_reg;
    assign bus.resp_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench: two responders (LATENCY 2 and 1) against a
// word-array memory model with per-transaction latency and back-pressure checks.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT0  = 2;
    localparam int LAT1  = 1;
`ifdef MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int checks = 0;
    int failures = 0;

    dmem_if bus0 ();
    dmem_if bus1 ();

    logic [1:0]  rv = '0, rw = '0, rr = '0;
    logic [31:0] ra [2];
    logic [31:0] wd [2];
    logic [1:0]  rq_rdy, rs_vld, rs_err;
    logic [31:0] rs_data [2];

    assign bus0.req_valid  = rv[0];
    assign bus0.req_write  = rw[0];
    assign bus0.req_addr   = ra[0];
    assign bus0.req_wdata  = wd[0];
    assign bus0.resp_ready = rr[0];
    assign bus1.req_valid  = rv[1];
    assign bus1.req_write  = rw[1];
    assign bus1.req_addr   = ra[1];
    assign bus1.req_wdata  = wd[1];
    assign bus1.resp_ready = rr[1];

    assign rq_rdy[0]  = bus0.req_ready;
    assign rs_vld[0]  = bus0.resp_valid;
    assign rs_err[0]  = bus0.resp_err;
    assign rs_data[0] = bus0.resp_rdata;
    assign rq_rdy[1]  = bus1.req_ready;
    assign rs_vld[1]  = bus1.resp_valid;
    assign rs_err[1]  = bus1.resp_err;
    assign rs_data[1] = bus1.resp_rdata;

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Reference memory: what each word holds after all accepted stores.
    logic [31:0] mem   [2][DEPTH];
    bit          known [2][DEPTH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_mis(input logic [31:0] a);
        return MIS_EN && (a[1:0] != 2'b00);
    endfunction

    task automatic run_txn(input int s, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int bp, input bit hold_valid,
                           output int wait_cyc, output int acc_cyc);
        int lat, n, idx;
        bit mis, chk_d;
        logic [31:0] exp_d, held;
        lat = (s == 0) ? LAT0 : LAT1;
        rv[s] = 1'b1; rw[s] = wr; ra[s] = addr; wd[s] = wdata; rr[s] = (bp == 0);
        wait_cyc = 0;
        while (!rq_rdy[s] && wait_cyc < 64) begin
            @(posedge clk); #1; wait_cyc++;
        end
        check_eq("accept_bound", 32'(wait_cyc < 64), 32'd1);
        @(posedge clk); #1;
        acc_cyc = cyc_cnt;
        if (!hold_valid) rv[s] = 1'b0;
        idx   = int'((addr >> 2) % DEPTH);
        mis   = is_mis(addr);
        chk_d = wr || mis || known[s][idx];
        exp_d = (wr || mis) ? 32'd0 : mem[s][idx];
        if (wr && !mis) begin
            mem[s][idx]   = wdata;
            known[s][idx] = 1'b1;
        end
        n = 1;
        while (!rs_vld[s] && n < 64) begin
            @(posedge clk); #1; n++;
        end
        check_eq("latency", n, lat);
        if (chk_d) check_eq("rdata", rs_data[s], exp_d);
        check_eq("err", {31'd0, rs_err[s]}, {31'd0, mis});
        check_eq("ready_in_resp", {31'd0, rq_rdy[s]}, 32'd0);
        held = rs_data[s];
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check_eq("bp_valid", {31'd0, rs_vld[s]}, 32'd1);
            check_eq("bp_stable", rs_data[s], held);
            check_eq("bp_ready", {31'd0, rq_rdy[s]}, 32'd0);
        end
        rr[s] = 1'b1;
        @(posedge clk); #1;
        rr[s] = 1'b0;
        check_eq("hs_valid_low", {31'd0, rs_vld[s]}, 32'd0);
        check_eq("hs_ready_high", {31'd0, rq_rdy[s]}, 32'd1);
        $display("txn dut=%0d wr=%0b addr=%h wdata=%h rdata=%h err=%0b lat=%0d bp=%0d",
                 s, wr, addr, wdata, held, rs_err[s], n, bp);
    endtask

    initial begin
        int w, a, a_prev, lat_idx;
        logic [31:0] addr;
        for (int s = 0; s < 2; s++) begin
            ra[s] = '0; wd[s] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[s][i] = '0; known[s][i] = 1'b0;
            end
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check_eq("rst_req_ready", {31'd0, rq_rdy[s]}, 32'd1);
            check_eq("rst_resp_valid", {31'd0, rs_vld[s]}, 32'd0);
            check_eq("rst_rdata", rs_data[s], 32'd0);
            check_eq("rst_err", {31'd0, rs_err[s]}, 32'd0);
        end
        #3 reset = 1'b1;
        @(posedge clk); #1;

        // Store then load, LATENCY 2
        run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, w, a);
        run_txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0, w, a);

        // Reset during WAIT: store survives, load is dropped with no response
        run_txn(0, 1'b1, 32'h40, 32'hCAFE0001, 0, 1'b0, w, a);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h44; wd[0] = 32'h0BAD_F00D; rr[0] = 1'b1;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        mem[0][17] = 32'h0BAD_F00D; known[0][17] = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_eq("midrst_valid", {31'd0, rs_vld[0]}, 32'd0);
        check_eq("midrst_ready", {31'd0, rq_rdy[0]}, 32'd1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h40;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_eq("dropped_load_silent", {31'd0, rs_vld[0]}, 32'd0);
        end
        rr[0] = 1'b0;
        run_txn(0, 1'b0, 32'h44, 32'h0, 0, 1'b0, w, a);

        // Back-pressure with req_valid held; next request accepted right after handshake
        run_txn(0, 1'b0, 32'h10, 32'h0, 5, 1'b1, w, a);
        a_prev = a;
        run_txn(0, 1'b0, 32'h44, 32'h0, 0, 1'b0, w, a);
        check_eq("bp_next_wait", w, 0);
        check_eq("bp_next_gap", a - a_prev, LAT0 + 1 + 5);

        // Address wrap
        run_txn(0, 1'b1, 32'h400, 32'h1234, 0, 1'b0, w, a);
        run_txn(0, 1'b0, 32'h000, 32'h0, 0, 1'b0, w, a);
        check_eq("wrap_value", mem[0][0], 32'h1234);

        // LATENCY 1 back-to-back loads
        for (int i = 0; i < 4; i++) run_txn(1, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 0, 1'b0, w, a);
        a_prev = -1;
        for (int i = 0; i < 4; i++) begin
            run_txn(1, 1'b0, 32'(i * 4), 32'h0, 0, 1'b0, w, a);
            if (a_prev >= 0) check_eq("lat1_period", a - a_prev, LAT1 + 1);
            a_prev = a;
        end

        // Misaligned store then aligned load of the same word
        run_txn(0, 1'b1, 32'h20, 32'h5555_AAAA, 0, 1'b0, w, a);
        run_txn(0, 1'b1, 32'h22, 32'h0000_FFFF, 0, 1'b0, w, a);
        run_txn(0, 1'b0, 32'h20, 32'h0, 0, 1'b0, w, a);

        // Randomised traffic on both instances
        for (int i = 0; i < 160; i++) begin
            lat_idx = int'($urandom_range(0, 1));
            addr = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            run_txn(lat_idx, 1'($urandom_range(0, 1)), addr, $urandom,
                    int'($urandom_range(0, 3)), 1'b0, w, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
